// File: rtl/vmul_pkg.sv
// Shared widths for the lane dot-product MAC.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package vmul_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int LANES      = 4;
  localparam int PROD_W     = 2 * DEF_DATA_W;
  localparam int SUM_W      = PROD_W + 2;
  localparam int DEF_ACC_W  = 32;

endpackage

// File: rtl/lane_mult.sv
// Registered unsigned DATA_W x DATA_W multiplier for one lane.
// Latency: 1 cycle from operands to product.
// Backpressure: product register holds while en is low.
module lane_mult #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic [2*DATA_W-1:0]   p
);

  localparam int PW = 2 * DATA_W;

  // Capture the full-width product whenever the pipeline is advancing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p <= '0;
    end else if (en) begin
      p <= PW'(a) * PW'(b);
    end
  end

endmodule

// File: rtl/vec_dot_mac.sv
// Four-lane unsigned dot product accumulated over a multi-beat vector.
// Latency: last beat accepted at edge k gives out_valid after edge k+2.
// Backpressure: out_valid && !out_ready freezes every stage; in_ready drops.
module vec_dot_mac
  import vmul_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W   // must be at least 2*DATA_W+2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] a2,
  input  logic [DATA_W-1:0] a3,
  input  logic [DATA_W-1:0] b0,
  input  logic [DATA_W-1:0] b1,
  input  logic [DATA_W-1:0] b2,
  input  logic [DATA_W-1:0] b3,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ACC_W-1:0]  result,
  output logic              ovf,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int PW = 2 * DATA_W;
  localparam int SW = PW + 2;

  logic              stall;
  logic              advance;
  logic              accept;
  logic [DATA_W-1:0] a_l [LANES];
  logic [DATA_W-1:0] b_l [LANES];
  logic [PW-1:0]     prod [LANES];

  logic              s1_vld, s1_last;
  logic [SW-1:0]     tree_sum;
  logic [SW-1:0]     s2_sum;
  logic              s2_vld, s2_last;

  logic [ACC_W-1:0]  acc;
  logic              ovf_sticky;
  logic [ACC_W:0]    acc_ext;
  logic [ACC_W-1:0]  nxt;
  logic              carry;

  // Stall depends only on registered out_valid plus the consumer's ready.
  assign stall    = out_valid && !out_ready;
  assign advance  = !stall;
  assign in_ready = advance;
  assign accept   = in_valid && in_ready;

  assign a_l[0] = a0;
  assign a_l[1] = a1;
  assign a_l[2] = a2;
  assign a_l[3] = a3;
  assign b_l[0] = b0;
  assign b_l[1] = b1;
  assign b_l[2] = b2;
  assign b_l[3] = b3;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_mult #(.DATA_W(DATA_W)) u_mult (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (advance),
      .a     (a_l[i]),
      .b     (b_l[i]),
      .p     (prod[i])
    );
  end

  // S1 control: tag the products; a non-accepting cycle loads a bubble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_last <= 1'b0;
    end else if (advance) begin
      s1_vld  <= accept;
      s1_last <= accept && in_last;
    end
  end

  // Adder tree: lanes zero-extended so the four-way sum never loses a bit.
  always_comb begin
    tree_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      tree_sum = tree_sum + SW'(prod[i]);
    end
  end

  // S2: register the lane sum alongside its control bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_sum  <= '0;
      s2_vld  <= 1'b0;
      s2_last <= 1'b0;
    end else if (advance) begin
      s2_sum  <= tree_sum;
      s2_vld  <= s1_vld;
      s2_last <= s1_last;
    end
  end

  // Wrapping add; the carry out of the top bit feeds the overflow flag.
  always_comb begin
    acc_ext = (ACC_W + 1)'(acc) + (ACC_W + 1)'(s2_sum);
    nxt     = acc_ext[ACC_W-1:0];
    carry   = acc_ext[ACC_W];
  end

  // S3: accumulate, publish on the last beat, and hold everything under stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc        <= '0;
      ovf_sticky <= 1'b0;
      result     <= '0;
      ovf        <= 1'b0;
      out_valid  <= 1'b0;
    end else if (advance) begin
      // Not stalled means any held result is being taken this edge.
      out_valid <= s2_vld && s2_last;
      if (s2_vld) begin
        if (s2_last) begin
          result     <= nxt;
          ovf        <= ovf_sticky | carry;
          acc        <= '0;
          ovf_sticky <= 1'b0;
        end else begin
          acc        <= nxt;
          ovf_sticky <= ovf_sticky | carry;
        end
      end
    end
  end

endmodule

// File: tb/tb_vec_dot_mac.sv
// Directed bench for vec_dot_mac: a 32-bit accumulator instance and an
// 18-bit one sharing the same stimulus, so overflow can be observed.
module tb_vec_dot_mac;

  logic       clk;
  logic       rst_n;
  logic [7:0] a0, a1, a2, a3, b0, b1, b2, b3;
  logic       in_valid, in_last, out_ready;

  logic        rdy_w, ovf_w, vld_w;
  logic [31:0] res_w;
  logic        rdy_n, ovf_n, vld_n;
  logic [17:0] res_n;

  int total = 0;
  int bad   = 0;

  vec_dot_mac #(.DATA_W(8), .ACC_W(32)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3),
    .b0(b0), .b1(b1), .b2(b2), .b3(b3),
    .in_valid(in_valid), .in_last(in_last), .in_ready(rdy_w),
    .result(res_w), .ovf(ovf_w), .out_valid(vld_w), .out_ready(out_ready)
  );

  vec_dot_mac #(.DATA_W(8), .ACC_W(18)) u_narrow (
    .clk(clk), .rst_n(rst_n),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3),
    .b0(b0), .b1(b1), .b2(b2), .b3(b3),
    .in_valid(in_valid), .in_last(in_last), .in_ready(rdy_n),
    .result(res_n), .ovf(ovf_n), .out_valid(vld_n), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one edge; all driving and sampling happens 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] x0, x1, x2, x3, y0, y1, y2, y3,
                      input logic v, input logic l);
    a0 = x0; a1 = x1; a2 = x2; a3 = x3;
    b0 = y0; b1 = y1; b2 = y2; b3 = y3;
    in_valid = v;
    in_last  = l;
  endtask

  task automatic idle();
    beat(8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    out_ready = 1'b1;
    // Reset with live input: nothing may leak into the outputs.
    beat(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 1'b1, 1'b1);
    tick();
    check("rst1_valid", 64'(vld_w), 64'd0);
    check("rst1_result", 64'(res_w), 64'd0);
    check("rst1_ovf", 64'(ovf_w), 64'd0);
    tick();
    check("rst2_valid", 64'(vld_w), 64'd0);
    check("rst2_result", 64'(res_w), 64'd0);
    check("rst2_ovf", 64'(ovf_w), 64'd0);
    rst_n = 1'b1;
    idle();
    tick();
    check("rst_in_ready", 64'(rdy_w), 64'd1);
    check("rst_post_valid", 64'(vld_w), 64'd0);

    // in_last without in_valid must not produce a result.
    in_last = 1'b1;
    tick(); tick(); tick();
    check("last_no_valid", 64'(vld_w), 64'd0);

    // Single-beat vector: 1*5+2*6+3*7+4*8 = 70.
    beat(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 1'b1, 1'b1);
    tick();
    idle();
    check("single_k0_valid", 64'(vld_w), 64'd0);
    tick();
    check("single_k1_valid", 64'(vld_w), 64'd0);
    tick();
    check("single_k2_valid", 64'(vld_w), 64'd1);
    check("single_result", 64'(res_w), 64'd70);
    check("single_ovf", 64'(ovf_w), 64'd0);
    tick();
    check("single_drain", 64'(vld_w), 64'd0);

    // Four beats of 0xFF lanes (4*4*65025 = 1040400), then a0=b0=2 back-to-back.
    for (int i = 0; i < 4; i++) begin
      beat(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, i == 3);
      tick();
    end
    beat(8'd2, 8'd0, 8'd0, 8'd0, 8'd2, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1);
    tick();
    idle();
    check("multi_pre_valid", 64'(vld_w), 64'd0);
    tick();
    check("multi_valid", 64'(vld_w), 64'd1);
    check("multi_result", 64'(res_w), 64'd1040400);
    check("multi_ovf", 64'(ovf_w), 64'd0);
    tick();
    check("b2b_valid", 64'(vld_w), 64'd1);
    check("b2b_result", 64'(res_w), 64'd4);
    tick();
    check("b2b_drain", 64'(vld_w), 64'd0);

    // Backpressure: two single-beat vectors while the consumer is not ready.
    out_ready = 1'b0;
    beat(8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 1'b1, 1'b1);
    tick();
    beat(8'd3, 8'd0, 8'd0, 8'd0, 8'd3, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1);
    tick();
    idle();
    check("bp_pre_valid", 64'(vld_w), 64'd0);
    tick();
    check("bp_first_valid", 64'(vld_w), 64'd1);
    check("bp_first_result", 64'(res_w), 64'd70);
    check("bp_in_ready_low", 64'(rdy_w), 64'd0);
    // Offered beats during the stall must be refused.
    beat(8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 8'd100, 1'b1, 1'b1);
    tick();
    check("bp_hold1_valid", 64'(vld_w), 64'd1);
    check("bp_hold1_result", 64'(res_w), 64'd70);
    tick();
    check("bp_hold2_result", 64'(res_w), 64'd70);
    check("bp_hold2_in_ready", 64'(rdy_w), 64'd0);
    idle();
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", 64'(rdy_w), 64'd1);
    tick();
    check("bp_second_valid", 64'(vld_w), 64'd1);
    check("bp_second_result", 64'(res_w), 64'd9);
    tick();
    check("bp_drain", 64'(vld_w), 64'd0);
    tick(); tick();
    check("bp_no_dup", 64'(vld_w), 64'd0);

    // Overflow: two beats of 0xFF lanes = 520200; mod 2^18 = 258056 with wrap.
    beat(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0);
    tick();
    in_last = 1'b1;
    tick();
    beat(8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1);
    tick();
    idle();
    tick();
    check("ovf_narrow_valid", 64'(vld_n), 64'd1);
    check("ovf_narrow_result", 64'(res_n), 64'd258056);
    check("ovf_narrow_flag", 64'(ovf_n), 64'd1);
    check("ovf_wide_result", 64'(res_w), 64'd520200);
    check("ovf_wide_flag", 64'(ovf_w), 64'd0);
    tick();
    check("ovf_next_valid", 64'(vld_n), 64'd1);
    check("ovf_next_result", 64'(res_n), 64'd1);
    check("ovf_next_flag", 64'(ovf_n), 64'd0);
    tick();

    // Mid-vector reset discards the partial sum and in-flight beats.
    beat(8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 1'b1, 1'b0);
    tick(); tick();
    rst_n = 1'b0;
    idle();
    tick();
    check("mrst_valid", 64'(vld_w), 64'd0);
    rst_n = 1'b1;
    beat(8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1);
    tick();
    idle();
    tick();
    check("mrst_pre_valid", 64'(vld_w), 64'd0);
    tick();
    check("mrst_valid_out", 64'(vld_w), 64'd1);
    check("mrst_result", 64'(res_w), 64'd1);
    check("mrst_ovf", 64'(ovf_w), 64'd0);
    check("mrst_narrow_result", 64'(res_n), 64'd1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
